pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: width, default 8, program-counter and return-address width in bits.
REQ-002 Parameter: depth, default 2; tracked return-stack capacity is 2**depth entries.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 step  input  1  execute one sequencing operation this cycle; ignored while busy=1 or fault=1.
REQ-006 jmp  input  1  with step: load pc from target.
REQ-007 call  input  1  with step: push return address, load pc from target.
REQ-008 ret  input  1  with step: pop return address into pc.
REQ-009 target  input  width  jump/call destination.
REQ-010 stk_full  input  1  stack full indication from the downstream stack.
REQ-011 stk_dout  input  width  popped data from the stack, valid the cycle after the stack samples a pop.
REQ-012 pc  output  width  current program counter.
REQ-013 busy  output  1  return in progress; step not accepted.
REQ-014 fault  output  1  sticky overflow/underflow flag.
REQ-015 stk_en  output  1  stack enable, registered.
REQ-016 stk_con  output  1  stack op, registered: 1=pop, 0=push.
REQ-017 stk_din  output  width  data to push, registered.
REQ-018 stk_clr  output  1  synchronous active-low stack clear, registered.

Function
REQ-019 FSM states SHALL be RUN, POP_REQ, POP_WAIT, FAULT.
REQ-020 Internal counter cnt (depth+1 bits) SHALL track stored entries, range 0..2**depth.
REQ-021 RUN, step=1: ret wins over call, call wins over jmp, jmp wins over increment; the lower-priority requests in the same cycle are dropped.
REQ-022 RUN, step=1, no jmp/call/ret: pc <= pc+1 modulo 2**width (all-ones wraps to 0).
REQ-023 RUN, step=1, jmp: pc <= target; no stack activity.
REQ-024 RUN, step=1, call, cnt<2**depth and stk_full=0: pc <= target, stk_din <= pc+1 (wrapped), stk_en <= 1, stk_con <= 0, cnt <= cnt+1.
REQ-025 RUN, step=1, call, cnt=2**depth or stk_full=1: go to FAULT; pc unchanged; no push.
REQ-026 RUN, step=1, ret, cnt>0: stk_en <= 1, stk_con <= 1, cnt <= cnt-1, go to POP_REQ.
REQ-027 RUN, step=1, ret, cnt=0: go to FAULT; pc unchanged; no pop.
REQ-028 POP_REQ (stack samples pop this cycle): go to POP_WAIT.
REQ-029 POP_WAIT: pc <= stk_dout, go to RUN; ret latency is 3 edges from acceptance to pc update.
REQ-030 busy SHALL be 1 exactly in POP_REQ and POP_WAIT.
REQ-031 stk_en SHALL pulse for exactly one cycle per accepted call/ret; stk_en=0 in all other cycles.
REQ-032 FAULT: fault=1, pc held, stk_en=0, step ignored; exit only by reset.
REQ-033 step=0: pc, cnt and state SHALL be unchanged; stk_en <= 0.

Reset
REQ-034 clr=0 SHALL immediately force pc=0, cnt=0, state=RUN, busy=0, fault=0, stk_en=0, stk_con=0, stk_din=0, stk_clr=0.
REQ-035 stk_clr SHALL stay 0 through the first posedge after clr rises and return to 1 on the second posedge; step is ignored during these two cycles.
REQ-036 Reset asserted in POP_REQ or POP_WAIT SHALL abort the return; the stale stk_dout is never loaded.

Verification
REQ-037 Reset release, step=1 for 3 cycles, no ops -> pc 0,1,2,3; stk_en stays 0.
REQ-038 pc=0x10, step+call target=0x40 -> next cycle pc=0x40, stk_en=1, stk_con=0, stk_din=0x11; then step+ret -> busy=1 for 2 cycles, stk_con=1, pc=0x11 after 3rd edge.
REQ-039 pc=0xFF, step, no op -> pc=0x00; pc=0xFF, call target=0x05 -> stk_din=0x00.
REQ-040 depth=2: 4 calls accepted, 5th call -> fault=1, pc unchanged, no 5th stk_en pulse; step thereafter has no effect.
REQ-041 After reset, step+ret -> fault=1, stk_en never asserted; step+call+ret+jmp together with cnt=1 -> ret executed only.
REQ-042 clr pulsed low during POP_WAIT -> pc=0, busy=0, stk_clr=0 asynchronously; pc stays 0 until new steps.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return through an external stack.
// Tracks stack occupancy locally and traps overflow/underflow into a sticky fault state.
module pc_sequencer #(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             step,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  input  logic [width-1:0] target,
  input  logic             stk_full,
  input  logic [width-1:0] stk_dout,
  output logic [width-1:0] pc,
  output logic             busy,
  output logic             fault,
  output logic             stk_en,
  output logic             stk_con,
  output logic [width-1:0] stk_din,
  output logic             stk_clr
);

  // state    | meaning
  // RUN      | accepting steps
  // POP_REQ  | stack samples the pop issued on entry
  // POP_WAIT | stk_dout valid, loaded into pc on exit
  // FAULT    | sticky overflow/underflow, left only by reset
  typedef enum logic [1:0] {RUN, POP_REQ, POP_WAIT, FAULT} state_t;

  localparam logic [depth:0] CNT_ONE = {{depth{1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [depth:0]   cnt, cnt_nx;
  logic [width-1:0] pc_nx, din_nx, pc_inc;
  logic             en_nx, con_nx;
  logic [1:0]       init_sr;
  logic             ready;

  // Two-cycle stack-clear window after reset release; steps are held off meanwhile.
  assign ready   = init_sr[1];
  assign stk_clr = init_sr[1];
  assign pc_inc  = pc + width'(1);
  assign busy    = (state == POP_REQ) || (state == POP_WAIT);
  assign fault   = (state == FAULT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= RUN;
      cnt     <= '0;
      pc      <= '0;
      stk_en  <= 1'b0;
      stk_con <= 1'b0;
      stk_din <= '0;
      init_sr <= 2'b00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pc      <= pc_nx;
      stk_en  <= en_nx;
      stk_con <= con_nx;
      stk_din <= din_nx;
      init_sr <= {init_sr[0], 1'b1};
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    din_nx   = stk_din;
    con_nx   = stk_con;
    en_nx    = 1'b0;
    case (state)
      RUN: begin
        if (step && ready) begin
          if (ret) begin
            if (cnt == '0) begin
              state_nx = FAULT;
            end else begin
              en_nx    = 1'b1;
              con_nx   = 1'b1;
              cnt_nx   = cnt - CNT_ONE;
              state_nx = POP_REQ;
            end
          end else if (call) begin
            // cnt MSB set means all 2**depth entries are in use
            if (cnt[depth] || stk_full) begin
              state_nx = FAULT;
            end else begin
              pc_nx  = target;
              din_nx = pc_inc;
              en_nx  = 1'b1;
              con_nx = 1'b0;
              cnt_nx = cnt + CNT_ONE;
            end
          end else if (jmp) begin
            pc_nx = target;
          end else begin
            pc_nx = pc_inc;
          end
        end
      end
      POP_REQ:  state_nx = POP_WAIT;
      POP_WAIT: begin
        pc_nx    = stk_dout;
        state_nx = RUN;
      end
      FAULT:    state_nx = FAULT;
      default:  state_nx = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized ops
// compared against a queue-based model of the return stack.
module tb_pc_sequencer;
  localparam int CAP = 4;

  logic       clk = 1'b0, clr = 1'b1;
  logic       step = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, stk_full = 1'b0;
  logic [7:0] target = 8'h00, stk_dout = 8'h00;
  logic [7:0] pc, stk_din;
  logic       busy, fault, stk_en, stk_con, stk_clr;

  pc_sequencer #(.width(8), .depth(2)) dut (
    .clk(clk), .clr(clr), .step(step), .jmp(jmp), .call(call), .ret(ret),
    .target(target), .stk_full(stk_full), .stk_dout(stk_dout),
    .pc(pc), .busy(busy), .fault(fault), .stk_en(stk_en), .stk_con(stk_con),
    .stk_din(stk_din), .stk_clr(stk_clr)
  );

  always #5 clk = ~clk;

  int         vectors = 0, miscompares = 0;
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_q[$];
  logic [7:0] dev_mem[$];
  bit         m_fault = 1'b0;
  int         m_events = 0, dev_events = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; also plays the downstream stack, which samples stk_en/stk_con/stk_din at the edge.
  task automatic tick();
    logic       den, dcon, dclr;
    logic [7:0] ddin;
    den = stk_en; dcon = stk_con; ddin = stk_din; dclr = stk_clr;
    @(posedge clk);
    #1;
    if (!dclr) dev_mem.delete();
    else if (den) begin
      dev_events++;
      if (dcon) stk_dout = (dev_mem.size() > 0) ? dev_mem.pop_back() : 8'hEE;
      else dev_mem.push_back(ddin);
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    step = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; stk_full = 1'b0;
  endtask

  task automatic idle();
    clear_in();
    tick();
    chk("idle.pc", pc, m_pc);
    chk("idle.stk_en", stk_en, 0);
    chk("idle.fault", fault, m_fault);
    chk("idle.busy", busy, 0);
    chk("idle.events", dev_events, m_events);
  endtask

  task automatic do_reset();
    clear_in();
    clr = 1'b0;
    #1;
    chk("rst.pc", pc, 0);
    chk("rst.busy", busy, 0);
    chk("rst.fault", fault, 0);
    chk("rst.stk_en", stk_en, 0);
    chk("rst.stk_con", stk_con, 0);
    chk("rst.stk_din", stk_din, 0);
    chk("rst.stk_clr", stk_clr, 0);
    tick();
    clr = 1'b1;
    step = 1'b1;
    tick();
    chk("rel1.stk_clr", stk_clr, 0);
    chk("rel1.pc", pc, 0);
    tick();
    chk("rel2.stk_clr", stk_clr, 1);
    chk("rel2.pc", pc, 0);
    step = 1'b0;
    m_pc = 8'h00; m_q.delete(); m_fault = 1'b0; m_events = 0; dev_events = 0;
  endtask

  task automatic do_step(input bit j, input bit c, input bit r, input logic [7:0] tgt, input bit full);
    logic [7:0] ra;
    step = 1'b1; jmp = j; call = c; ret = r; target = tgt; stk_full = full;
    if (m_fault) begin
      tick(); clear_in();
      chk("flt.pc", pc, m_pc);
      chk("flt.fault", fault, 1);
      chk("flt.stk_en", stk_en, 0);
    end else if (r) begin
      if (m_q.size() == 0) begin
        m_fault = 1'b1;
        tick(); clear_in();
        chk("ret_uf.fault", fault, 1);
        chk("ret_uf.pc", pc, m_pc);
        chk("ret_uf.stk_en", stk_en, 0);
      end else begin
        ra = m_q.pop_back();
        m_events++;
        tick();
        step = 1'($urandom_range(0, 1)); jmp = 1'($urandom_range(0, 1));
        call = 1'($urandom_range(0, 1)); ret = 1'($urandom_range(0, 1)); target = 8'($urandom);
        chk("ret1.busy", busy, 1);
        chk("ret1.stk_en", stk_en, 1);
        chk("ret1.stk_con", stk_con, 1);
        chk("ret1.pc", pc, m_pc);
        tick();
        chk("ret2.busy", busy, 1);
        chk("ret2.stk_en", stk_en, 0);
        chk("ret2.pc", pc, m_pc);
        tick(); clear_in();
        m_pc = ra;
        chk("ret3.busy", busy, 0);
        chk("ret3.pc", pc, m_pc);
        chk("ret3.stk_en", stk_en, 0);
      end
    end else if (c) begin
      if (m_q.size() == CAP || full) begin
        m_fault = 1'b1;
        tick(); clear_in();
        chk("call_of.fault", fault, 1);
        chk("call_of.pc", pc, m_pc);
        chk("call_of.stk_en", stk_en, 0);
      end else begin
        ra = m_pc + 8'd1;
        m_q.push_back(ra);
        m_events++;
        m_pc = tgt;
        tick(); clear_in();
        chk("call.pc", pc, m_pc);
        chk("call.stk_en", stk_en, 1);
        chk("call.stk_con", stk_con, 0);
        chk("call.stk_din", stk_din, ra);
      end
    end else begin
      m_pc = j ? tgt : m_pc + 8'd1;
      tick(); clear_in();
      chk("seq.pc", pc, m_pc);
      chk("seq.stk_en", stk_en, 0);
      chk("seq.busy", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // sequential increment after reset release
    for (int i = 0; i < 3; i++) do_step(0, 0, 0, 8'h00, 0);
    chk("inc3.pc_const", pc, 3);
    idle();

    // call from 0x10 to 0x40, then return
    do_step(1, 0, 0, 8'h10, 0);
    do_step(0, 1, 0, 8'h40, 0);
    chk("call40.din_const", stk_din, 8'h11);
    idle();
    do_step(0, 0, 1, 8'h00, 0);
    chk("ret11.pc_const", pc, 8'h11);
    idle();

    // wrap-around of pc and of the pushed return address
    do_step(1, 0, 0, 8'hFF, 0);
    do_step(0, 0, 0, 8'h00, 0);
    chk("wrap.pc_const", pc, 8'h00);
    do_step(1, 0, 0, 8'hFF, 0);
    do_step(0, 1, 0, 8'h05, 0);
    chk("wrap.din_const", stk_din, 8'h00);
    idle();
    do_step(0, 0, 1, 8'h00, 0);
    idle();

    // priority: ret beats call and jmp with one entry stacked
    do_step(1, 0, 0, 8'h20, 0);
    do_step(0, 1, 0, 8'h60, 0);
    idle();
    do_step(1, 1, 1, 8'h99, 0);
    chk("prio.pc_const", pc, 8'h21);
    idle();

    // stk_full blocks a call
    do_step(0, 1, 0, 8'h33, 1);
    idle();
    do_step(0, 0, 0, 8'h00, 0);
    do_reset();

    // underflow right after reset
    do_step(0, 0, 1, 8'h00, 0);
    idle();
    do_reset();

    // overflow on the fifth nested call
    for (int i = 0; i < 5; i++) begin
      do_step(0, 1, 0, 8'($urandom), 0);
      idle();
    end
    chk("ovf.events_const", dev_events, 4);
    do_step(1, 0, 0, 8'h77, 0);
    do_step(0, 0, 0, 8'h00, 0);
    idle();
    do_reset();

    // randomized ops
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) idle();
      else do_step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
      if (m_fault) begin
        idle();
        do_reset();
      end
    end
    idle();

    // reset in POP_WAIT aborts the return
    do_step(1, 0, 0, 8'h30, 0);
    do_step(0, 1, 0, 8'h50, 0);
    idle();
    step = 1'b1; ret = 1'b1;
    tick();
    clear_in();
    tick();
    chk("abort.busy_before", busy, 1);
    do_reset();
    for (int i = 0; i < 3; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
